mem_req_arbiter: RTL

// Shares one tagged memory-controller port (mem_req/mem_resp) between N_CLIENTS masters, e.g. soft CPU plus DMA.

---
 rtl/mem_bus_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mem_req_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus widths and the arbiter state encoding used by the
// tagged memory-controller front end.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 26;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_TAG_W  = 8;
    localparam int MEM_BE_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first eligible client after last_grant,
// wrapping, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [N_CLIENTS-1:0] eligible,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [N_CLIENTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_vld
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        // Offset k walks outward from last_grant; the first hit wins.
        for (int k = 1; k <= N_CLIENTS; k++) begin
            for (int j = 0; j < N_CLIENTS; j++) begin
                if (!grant_vld && eligible[j] &&
                    (j == ((int'(last_grant) + k) % N_CLIENTS))) begin
                    grant_vld = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one tagged memory-controller port between N_CLIENTS masters; the
// client id rides in the tag MSBs so responses route back without a table.
module mem_req_arbiter
    import mem_bus_pkg::*;
#(
    parameter int N_CLIENTS      = 2,
    parameter int ID_BITS        = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                                    clk_clk,
    input  logic                                    reset_reset_n,
    input  logic [N_CLIENTS-1:0]                    cli_req_request,
    input  logic [N_CLIENTS-1:0]                    cli_req_read_writen,
    input  logic [N_CLIENTS*MEM_ADDR_W-1:0]         cli_req_address,
    input  logic [N_CLIENTS*MEM_BE_W-1:0]           cli_req_byte_en,
    input  logic [N_CLIENTS*MEM_DATA_W-1:0]         cli_req_wdata,
    input  logic [N_CLIENTS*(MEM_TAG_W-ID_BITS)-1:0] cli_req_tag,
    output logic [N_CLIENTS*(MEM_TAG_W-ID_BITS)-1:0] cli_resp_rack_tag,
    output logic [N_CLIENTS*(MEM_TAG_W-ID_BITS)-1:0] cli_resp_dack_tag,
    output logic [MEM_DATA_W-1:0]                   cli_resp_data,
    output logic                                    mem_req_request,
    output logic                                    mem_req_read_writen,
    output logic [MEM_ADDR_W-1:0]                   mem_req_address,
    output logic [MEM_BE_W-1:0]                     mem_req_byte_en,
    output logic [MEM_DATA_W-1:0]                   mem_req_wdata,
    output logic [MEM_TAG_W-1:0]                    mem_req_tag,
    input  logic [MEM_TAG_W-1:0]                    mem_resp_rack_tag,
    input  logic [MEM_TAG_W-1:0]                    mem_resp_dack_tag,
    input  logic [MEM_DATA_W-1:0]                   mem_resp_data,
    input  logic                                    err_clear,
    output logic                                    timeout_err,
    output logic                                    tag_err
);

    localparam int CT_W  = MEM_TAG_W - ID_BITS;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [ID_BITS-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   req_q, req_d;
    logic                   rw_q, rw_d;
    logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
    logic [MEM_BE_W-1:0]    be_q, be_d;
    logic [MEM_DATA_W-1:0]  wdata_q, wdata_d;
    logic [MEM_TAG_W-1:0]   tag_q, tag_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   tag_err_q, tag_err_d;

    logic [N_CLIENTS-1:0]   eligible;
    logic [N_CLIENTS-1:0]   zero_tag;
    logic [N_CLIENTS-1:0]   grant;
    logic [ID_BITS-1:0]     grant_idx;
    logic                   grant_vld;
    logic                   timeout_set;

    logic                   sel_rw;
    logic [MEM_ADDR_W-1:0]  sel_addr;
    logic [MEM_BE_W-1:0]    sel_be;
    logic [MEM_DATA_W-1:0]  sel_wdata;
    logic [CT_W-1:0]        sel_tag;

    // A zero client tag would be indistinguishable from "no response".
    always_comb begin
        eligible = '0;
        zero_tag = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            eligible[i] = cli_req_request[i] & (|cli_req_tag[i*CT_W +: CT_W]);
            zero_tag[i] = cli_req_request[i] & ~(|cli_req_tag[i*CT_W +: CT_W]);
        end
    end

    rr_arbiter #(
        .N_CLIENTS (N_CLIENTS),
        .IDX_W     (ID_BITS)
    ) u_rr_arbiter (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        sel_tag   = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            sel_rw    = sel_rw    | (grant[i] & cli_req_read_writen[i]);
            sel_addr  = sel_addr  | ({MEM_ADDR_W{grant[i]}} & cli_req_address[i*MEM_ADDR_W +: MEM_ADDR_W]);
            sel_be    = sel_be    | ({MEM_BE_W{grant[i]}}   & cli_req_byte_en[i*MEM_BE_W +: MEM_BE_W]);
            sel_wdata = sel_wdata | ({MEM_DATA_W{grant[i]}} & cli_req_wdata[i*MEM_DATA_W +: MEM_DATA_W]);
            sel_tag   = sel_tag   | ({CT_W{grant[i]}}       & cli_req_tag[i*CT_W +: CT_W]);
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        req_d        = req_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        tag_d        = tag_q;
        timeout_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d = ST_ISSUE;
                    req_d   = 1'b1;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    be_d    = sel_be;
                    wdata_d = sel_wdata;
                    tag_d   = {grant_idx, sel_tag};
                    count_d = '0;
                end
            end
            ST_ISSUE: begin
                if (mem_resp_rack_tag == tag_q) begin
                    state_d      = ST_IDLE;
                    req_d        = 1'b0;
                    last_grant_d = tag_q[MEM_TAG_W-1 -: ID_BITS];
                end else if (count_q != CNT_MAX) begin
                    // Overdue rack is only flagged; the request stays posted.
                    count_d     = count_q + 1'b1;
                    timeout_set = (count_q == CNT_LAST);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        timeout_err_d = timeout_set | (timeout_err_q & ~err_clear);
        tag_err_d     = (|zero_tag) | (tag_err_q & ~err_clear);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= ID_BITS'(N_CLIENTS - 1);
            count_q       <= '0;
            req_q         <= 1'b0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            tag_q         <= '0;
            timeout_err_q <= 1'b0;
            tag_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            count_q       <= count_d;
            req_q         <= req_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            tag_q         <= tag_d;
            timeout_err_q <= timeout_err_d;
            tag_err_q     <= tag_err_d;
        end
    end

    assign mem_req_request     = req_q;
    assign mem_req_read_writen = rw_q;
    assign mem_req_address     = addr_q;
    assign mem_req_byte_en     = be_q;
    assign mem_req_wdata       = wdata_q;
    assign mem_req_tag         = tag_q;
    assign timeout_err         = timeout_err_q;
    assign tag_err             = tag_err_q;

    // Responses bypass the FSM so in-flight reads finish regardless of grant.
    always_comb begin
        cli_resp_rack_tag = '0;
        cli_resp_dack_tag = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if ((|mem_resp_rack_tag) &&
                (mem_resp_rack_tag[MEM_TAG_W-1 -: ID_BITS] == ID_BITS'(i)))
                cli_resp_rack_tag[i*CT_W +: CT_W] = mem_resp_rack_tag[CT_W-1:0];
            if ((|mem_resp_dack_tag) &&
                (mem_resp_dack_tag[MEM_TAG_W-1 -: ID_BITS] == ID_BITS'(i)))
                cli_resp_dack_tag[i*CT_W +: CT_W] = mem_resp_dack_tag[CT_W-1:0];
        end
        cli_resp_data = mem_resp_data;
    end

endmodule
